spoc_rate_buf: RTL and testbench
================================

SPOC_RATE_BUF -- requirements
Module: spoc_rate_buf

Interface
REQ-001 SHALL have parameter PW, default 32, meaning public data bus width in bits; it is a multiple of 8.
REQ-002 SHALL have parameter RATE, default 64, meaning sponge rate in bits; it is a multiple of PW and at most 256.
REQ-003 SHALL define derived widths: NB = PW/8; NW = RATE/PW; CW = clog2(RATE/8)+1; SZW = clog2(NB)+1.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port bdi, input, PW bits: segment data word, MSB byte first.
REQ-007 SHALL have port bdi_size, input, SZW bits: valid bytes in bdi, range 1..NB, left-aligned.
REQ-008 SHALL have port bdi_eot, input, 1 bit: bdi is the last word of the segment.
REQ-009 SHALL have ports bdi_valid (input, 1 bit) and bdi_ready (output, 1 bit): bdi handshake.
REQ-010 SHALL have port dec, input, 1 bit: decrypt mode, sampled on the first accepted word of a block.
REQ-011 SHALL have port emit_en, input, 1 bit: produce a bdo stream for the current block.
REQ-012 SHALL have port ks, input, RATE bits: keystream (state rate part), stable while blk_valid=1.
REQ-013 SHALL have port clr, input, 1 bit: synchronous abort/clear.
REQ-014 SHALL have port blk_data, output, RATE bits: padded block to absorb.
REQ-015 SHALL have ports blk_valid (output, 1 bit) and blk_ready (input, 1 bit): block handshake.
REQ-016 SHALL have port blk_partial, output, 1 bit: block byte count is below RATE/8.
REQ-017 SHALL have port blk_last, output, 1 bit: block closed by bdi_eot.
REQ-018 SHALL have port blk_bytes, output, CW bits: byte count of the block.
REQ-019 SHALL have port bdo, output, PW bits: ct/pt output word.
REQ-020 SHALL have ports bdo_valid (output, 1 bit) and bdo_ready (input, 1 bit): bdo handshake.
REQ-021 SHALL have port bdo_size, output, SZW bits: valid bytes in bdo.
REQ-022 SHALL have port bdo_last, output, 1 bit: final bdo word of the block.

Function
REQ-023 SHALL implement FSM states FILL, HOLD, EMIT; bdi_ready=1 only in FILL, blk_valid=1 only in HOLD, bdo_valid=1 only in EMIT.
REQ-024 FILL: on bdi_valid&bdi_ready, SHALL write bdi into raw word slot widx (slot 0 = RATE MSBs), zero bytes beyond bdi_size, add bdi_size to cum, and increment widx.
REQ-025 FILL SHALL go to HOLD after an accepted word when widx reaches NW-1, when bdi_eot=1, or when bdi_size<NB; blk_last = bdi_eot of that word.
REQ-026 HOLD: blk_data SHALL be src = raw when dec=0, or raw XOR (ks masked to cum bytes) when dec=1, with pad applied: if cum<RATE/8 byte cum = 0x80 and later bytes 0; if cum=RATE/8 no pad; if cum=0 all-zero.
REQ-027 HOLD SHALL drive blk_partial = (cum<RATE/8), blk_bytes = cum, combinationally from registers and ks.
REQ-028 On blk_valid&blk_ready with emit_en=1 and cum>0, SHALL capture ks into ks_reg and go to EMIT; otherwise SHALL clear raw/cum/widx and go to FILL.
REQ-029 EMIT SHALL output word k (k=0..ceil(cum/NB)-1) as raw_k XOR ks_reg_k with bytes at or beyond cum zeroed; bdo_size = min(NB, cum-k*NB); bdo_last on final word.
REQ-030 EMIT SHALL advance only on bdo_ready; after the last word is accepted it SHALL clear raw/cum/widx and enter FILL on the next cycle.
REQ-031 clr=1 SHALL force FILL and clear raw, cum, widx, ks_reg in the next cycle from any state, overriding every handshake in that cycle.
REQ-032 cum arithmetic SHALL be CW bits and never wrap; one block holds at most RATE/8 bytes.
REQ-033 Outputs SHALL hold stable while valid=1 and ready=0.
REQ-034 Latency: the block SHALL be presented on the cycle after its closing word is accepted; the first bdo word SHALL be presented on the cycle after the block is accepted.

Reset
REQ-035 rst=0 SHALL immediately set state FILL, raw=0, ks_reg=0, cum=0, widx=0.
REQ-036 During reset, outputs SHALL be bdi_ready=1, blk_valid=0, bdo_valid=0, blk_data=0, bdo=0, blk_last=0, blk_partial=1.
REQ-037 Reset asserted mid-block SHALL discard the partial block without emitting any output.

Verification (PW=32, RATE=64)
REQ-038 Words 0x11223344 (size 4) and 0x55667788 (size 4, eot=1) -> blk_data=0x1122334455667788, blk_partial=0, blk_last=1, blk_bytes=8.
REQ-039 Single word 0xAABBCCDD with size 3 and eot=1 -> blk_data=0xAABBCC8000000000, blk_partial=1, blk_bytes=3.
REQ-040 dec=0, emit_en=1, ks=0xFFFFFFFFFFFFFFFF, 5-byte block 0x0102030405 -> bdo words 0xFEFDFCFB (size 4), then 0xFA000000 (size 1, bdo_last=1).
REQ-041 Empty segment (eot with cum=0 via clr-then-flush) -> blk_data=0, no bdo words emitted.
REQ-042 bdo_ready held 0 for 3 cycles in EMIT -> bdo stable; then clr=1 -> FILL next cycle, bdi_ready=1, cum=0.
REQ-043 rst pulsed low during FILL after one word -> blk_valid never asserts; the next two-word block is correct.

Source files
------------

// File: rtl/spoc_rate_buf.sv
// spoc_rate_buf: gathers PW-bit segment words into one RATE-bit sponge block,
// pads it, offers it for absorption, then optionally streams ct/pt words out.
//
// Ports
//   clk, rst                      clock / async active-low reset
//   bdi, bdi_size, bdi_eot        input word, valid bytes (left aligned), end of segment
//   bdi_valid, bdi_ready          input handshake (ready only while filling)
//   dec                           decrypt mode, sampled on the first word of a block
//   emit_en                       stream bdo for this block, sampled at block handshake
//   ks                            rate part of the state (keystream)
//   clr                           synchronous abort, wins over every handshake
//   blk_data/valid/ready          padded block handshake
//   blk_partial, blk_last, blk_bytes  block attributes
//   bdo, bdo_size, bdo_last       ct/pt output word stream
//   bdo_valid, bdo_ready          output handshake
module spoc_rate_buf #(
  parameter  int PW   = 32,
  parameter  int RATE = 64,
  localparam int NB   = PW / 8,
  localparam int NW   = RATE / PW,
  localparam int RB   = RATE / 8,
  localparam int CW   = $clog2(RB) + 1,
  localparam int SZW  = $clog2(NB) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PW-1:0]   bdi,
  input  logic [SZW-1:0]  bdi_size,
  input  logic            bdi_eot,
  input  logic            bdi_valid,
  output logic            bdi_ready,
  input  logic            dec,
  input  logic            emit_en,
  input  logic [RATE-1:0] ks,
  input  logic            clr,
  output logic [RATE-1:0] blk_data,
  output logic            blk_valid,
  input  logic            blk_ready,
  output logic            blk_partial,
  output logic            blk_last,
  output logic [CW-1:0]   blk_bytes,
  output logic [PW-1:0]   bdo,
  output logic            bdo_valid,
  input  logic            bdo_ready,
  output logic [SZW-1:0]  bdo_size,
  output logic            bdo_last
);

  localparam int              WIW     = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0]   RB_C    = CW'(RB);
  localparam logic [SZW-1:0]  NB_S    = SZW'(NB);
  localparam logic [WIW-1:0]  WI_LAST = WIW'(NW - 1);

  typedef enum logic [1:0] {FILL, HOLD, EMIT} state_t;

  state_t          state, state_nx;
  logic [RATE-1:0] raw, ks_reg;
  logic [CW-1:0]   cum;
  logic [WIW-1:0]  widx, ecnt;
  logic            dec_reg, last_reg;

  // ---------------- input word shaping ----------------
  logic [SZW-1:0] sz;
  logic [PW-1:0]  bdi_m;
  logic [CW:0]    cum_sum;
  logic [CW-1:0]  cum_nx;
  logic           closing;

  // out-of-range sizes are clamped so cum can never run past one block
  assign sz      = (bdi_size > NB_S) ? NB_S : bdi_size;
  assign cum_sum = {1'b0, cum} + (CW+1)'(sz);
  assign cum_nx  = (cum_sum > {1'b0, RB_C}) ? RB_C : cum_sum[CW-1:0];
  assign closing = (widx == WI_LAST) || bdi_eot || (sz < NB_S);

  always_comb begin
    bdi_m = '0;
    for (int j = 0; j < NB; j++)
      if (SZW'(j) < sz) bdi_m[PW-1-8*j -: 8] = bdi[PW-1-8*j -: 8];
  end

  // ---------------- padded block ----------------
  // Bytes past cum are already zero in raw, so the pad byte lands on zeros.
  logic [RATE-1:0] pad;
  always_comb begin
    pad = '0;
    for (int i = 0; i < RB; i++) begin
      if (CW'(i) < cum)
        pad[RATE-1-8*i -: 8] = raw[RATE-1-8*i -: 8] ^ (dec_reg ? ks[RATE-1-8*i -: 8] : 8'h00);
      else if ((CW'(i) == cum) && (cum != '0))
        pad[RATE-1-8*i -: 8] = 8'h80;
    end
  end

  // ---------------- emit word ----------------
  logic [PW-1:0]  ew, ew_m;
  logic [SZW-1:0] e_size;
  logic           e_last;
  int             ebase, erem;

  always_comb begin
    ew    = raw[RATE-1-int'(ecnt)*PW -: PW] ^ ks_reg[RATE-1-int'(ecnt)*PW -: PW];
    ebase = int'(ecnt) * NB;
    erem  = int'(cum) - ebase;
    ew_m  = '0;
    for (int j = 0; j < NB; j++)
      if (j < erem) ew_m[PW-1-8*j -: 8] = ew[PW-1-8*j -: 8];
    e_last = (erem <= NB);
    e_size = (erem >= NB) ? NB_S : SZW'(erem);
  end

  // ---------------- outputs ----------------
  assign bdi_ready   = (state == FILL);
  assign blk_valid   = (state == HOLD);
  assign bdo_valid   = (state == EMIT);
  assign blk_data    = blk_valid ? pad : '0;
  assign blk_partial = (cum < RB_C);
  assign blk_bytes   = cum;
  assign blk_last    = blk_valid & last_reg;
  assign bdo         = bdo_valid ? ew_m : '0;
  assign bdo_size    = bdo_valid ? e_size : '0;
  assign bdo_last    = bdo_valid & e_last;

  // ---------------- FSM ----------------
  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (bdi_valid && closing) state_nx = HOLD;
      HOLD:    if (blk_ready) state_nx = (emit_en && (cum != '0)) ? EMIT : FILL;
      EMIT:    if (bdo_ready && e_last) state_nx = FILL;
      default: state_nx = FILL;
    endcase
    if (clr) state_nx = FILL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      raw      <= '0;
      ks_reg   <= '0;
      cum      <= '0;
      widx     <= '0;
      ecnt     <= '0;
      dec_reg  <= 1'b0;
      last_reg <= 1'b0;
    end else if (clr) begin
      state    <= FILL;
      raw      <= '0;
      ks_reg   <= '0;
      cum      <= '0;
      widx     <= '0;
      ecnt     <= '0;
      dec_reg  <= 1'b0;
      last_reg <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        FILL: if (bdi_valid) begin
          raw[RATE-1-int'(widx)*PW -: PW] <= bdi_m;
          cum      <= cum_nx;
          widx     <= widx + WIW'(1);
          last_reg <= bdi_eot;
          if (widx == '0) dec_reg <= dec;
        end
        HOLD: if (blk_ready) begin
          ecnt <= '0;
          if (emit_en && (cum != '0)) begin
            ks_reg <= ks;
          end else begin
            raw  <= '0;
            cum  <= '0;
            widx <= '0;
          end
        end
        EMIT: if (bdo_ready) begin
          if (e_last) begin
            raw  <= '0;
            cum  <= '0;
            widx <= '0;
            ecnt <= '0;
          end else begin
            ecnt <= ecnt + WIW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spoc_rate_buf.sv
// Bench for spoc_rate_buf (PW=32, RATE=64): directed and random blocks, with a
// byte-level reference model feeding block/bdo scoreboards checked by a monitor.
module tb_spoc_rate_buf;
  localparam int PW = 32, RATE = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bdi = '0;
  logic [2:0]  bdi_size = '0;
  logic        bdi_eot = 1'b0, bdi_valid = 1'b0, bdi_ready;
  logic        dec = 1'b0, emit_en = 1'b0, clr = 1'b0;
  logic [63:0] ks = '0;
  logic [63:0] blk_data;
  logic        blk_valid, blk_ready = 1'b0, blk_partial, blk_last;
  logic [3:0]  blk_bytes;
  logic [31:0] bdo;
  logic        bdo_valid, bdo_ready = 1'b0, bdo_last;
  logic [2:0]  bdo_size;

  spoc_rate_buf #(.PW(PW), .RATE(RATE)) dut (
    .clk(clk), .rst(rst), .bdi(bdi), .bdi_size(bdi_size), .bdi_eot(bdi_eot),
    .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .dec(dec), .emit_en(emit_en),
    .ks(ks), .clr(clr), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_partial(blk_partial), .blk_last(blk_last),
    .blk_bytes(blk_bytes), .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
    .bdo_size(bdo_size), .bdo_last(bdo_last));

  always #5 clk = ~clk;

  typedef struct {logic [63:0] data; logic partial; logic last; logic [3:0] bytes;} blk_t;
  typedef struct {logic [31:0] data; logic [2:0] size; logic last;} bdo_t;

  blk_t blk_q[$];
  bdo_t bdo_q[$];
  int   tests = 0, fails = 0;
  bit   force_rdy = 1'b0, f_blk = 1'b0, f_bdo = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / ready driver ----------------
  initial begin
    bit          hb = 1'b0, ho = 1'b0;
    logic [63:0] s_bd;
    logic [3:0]  s_bb;
    logic        s_bl;
    logic [31:0] s_od;
    logic [2:0]  s_os;
    logic        s_ol;
    blk_t        eb;
    bdo_t        eo;
    forever begin
      @(negedge clk);
      if (force_rdy) begin
        blk_ready = f_blk;
        bdo_ready = f_bdo;
      end else begin
        blk_ready = ($urandom_range(0, 3) != 0);
        bdo_ready = ($urandom_range(0, 3) != 0);
      end
      if (hb && blk_valid) chk("blk_stable", {blk_data ^ s_bd, 3'b0, blk_last ^ s_bl, blk_bytes ^ s_bb}, '0);
      if (ho && bdo_valid) chk("bdo_stable", {bdo ^ s_od, 4'b0, bdo_size ^ s_os, bdo_last ^ s_ol}, '0);
      hb = blk_valid && !blk_ready;
      ho = bdo_valid && !bdo_ready;
      s_bd = blk_data; s_bb = blk_bytes; s_bl = blk_last;
      s_od = bdo; s_os = bdo_size; s_ol = bdo_last;
      if (blk_valid && blk_ready) begin
        if (blk_q.size() == 0) chk("blk_unexpected", 1, 0);
        else begin
          eb = blk_q.pop_front();
          chk("blk_data", blk_data, eb.data);
          chk("blk_attr", {blk_partial, blk_last, blk_bytes}, {eb.partial, eb.last, eb.bytes});
        end
      end
      if (bdo_valid && bdo_ready) begin
        if (bdo_q.size() == 0) chk("bdo_unexpected", 1, 0);
        else begin
          eo = bdo_q.pop_front();
          chk("bdo_data", bdo, eo.data);
          chk("bdo_attr", {bdo_size, bdo_last}, {eo.size, eo.last});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_word(input logic [31:0] w, input logic [2:0] sz, input bit eot);
    int t = 0;
    bdi = w; bdi_size = sz; bdi_eot = eot; bdi_valid = 1'b1;
    while (!bdi_ready && t < 300) begin @(negedge clk); t++; end
    if (!bdi_ready) chk("bdi_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bdi_valid = 1'b0;
  endtask

  task automatic wait_fill();
    int t = 0;
    @(negedge clk);
    while (!bdi_ready && t < 300) begin @(negedge clk); t++; end
    if (!bdi_ready) chk("fill_timeout", 0, 1);
  endtask

  // Reference: block = first n bytes of d (MSB first), optionally XORed with
  // ks for decrypt, then 0x80 pad; bdo = data bytes XOR ks in 4-byte chunks.
  task automatic send_block(input int n, input logic [63:0] d, input bit eot_req,
                            input bit dec_i, input bit emit_i, input logic [63:0] ks_i,
                            input bit track_bdo, input bit wait_done);
    blk_t        eb;
    bdo_t        ob;
    bit          eot;
    int          nw, sz, i;
    logic [31:0] w;
    eot = eot_req || (n == 4);
    dec = dec_i; emit_en = emit_i; ks = ks_i;
    eb.data = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < n) eb.data[63-8*b -: 8] = dec_i ? (d[63-8*b -: 8] ^ ks_i[63-8*b -: 8]) : d[63-8*b -: 8];
      else if (b == n && n > 0) eb.data[63-8*b -: 8] = 8'h80;
    end
    eb.partial = (n < 8); eb.last = eot; eb.bytes = 4'(n);
    blk_q.push_back(eb);
    if (emit_i && n > 0 && track_bdo)
      for (int k = 0; k < (n + 3) / 4; k++) begin
        ob.data = '0;
        for (int j = 0; j < 4; j++) begin
          i = 4 * k + j;
          if (i < n) ob.data[31-8*j -: 8] = d[63-8*i -: 8] ^ ks_i[63-8*i -: 8];
        end
        ob.size = 3'((n - 4 * k > 4) ? 4 : n - 4 * k);
        ob.last = (4 * k + 4 >= n);
        bdo_q.push_back(ob);
      end
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      sz = (n - 4 * k > 4) ? 4 : n - 4 * k;
      w  = $urandom;   // junk beyond sz must be dropped by the DUT
      for (int j = 0; j < sz; j++) w[31-8*j -: 8] = d[63-8*(4*k+j) -: 8];
      send_word(w, 3'(sz), eot && (k == nw - 1));
    end
    if (wait_done) wait_fill();
  endtask

  initial begin
    int          t;
    logic [31:0] s_o;
    logic [2:0]  s_s;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bdi_ready", bdi_ready, 1);
    chk("rst_valids", {blk_valid, bdo_valid}, 0);
    chk("rst_blk_data", blk_data, 0);
    chk("rst_bdo", bdo, 0);
    chk("rst_blk_flags", {blk_last, blk_partial}, 2'b01);
    rst = 1'b1;
    @(negedge clk);

    // two full words, eot
    send_block(8, 64'h1122334455667788, 1, 0, 0, 64'h0, 1, 1);
    // single 3-byte word
    send_block(3, 64'hAABBCC0000000000, 1, 0, 0, 64'h0, 1, 1);
    // 5-byte encrypt/emit with all-ones keystream
    send_block(5, 64'h0102030405000000, 1, 0, 1, 64'hFFFFFFFFFFFFFFFF, 1, 1);
    // decrypt block with emit
    send_block(6, 64'h0123456789AB0000, 0, 1, 1, 64'h0F1E2D3C4B5A6978, 1, 1);

    // empty segment after clr: size-0 eot word
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    send_block(0, {$urandom, $urandom}, 1, 0, 1, {$urandom, $urandom}, 1, 1);

    // bdo stalled 3 cycles, then aborted with clr
    force_rdy = 1'b1; f_blk = 1'b1; f_bdo = 1'b0;
    send_block(6, 64'h1020304050600000, 1, 0, 1, {$urandom, $urandom}, 0, 0);
    t = 0;
    while (!bdo_valid && t < 100) begin @(negedge clk); t++; end
    chk("stall_bdo_valid", bdo_valid, 1);
    s_o = bdo; s_s = bdo_size;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_hold", {bdo_valid, bdo, bdo_size}, {1'b1, s_o, s_s});
    end
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("clr_state", {bdi_ready, bdo_valid, blk_valid}, 3'b100);
    chk("clr_cum", blk_bytes, 0);
    force_rdy = 1'b0;
    @(negedge clk);

    // reset in the middle of a block
    send_word(32'hDEADBEEF, 3'd4, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_out", {bdi_ready, blk_valid, bdo_valid, blk_partial, blk_bytes}, {4'b1001, 4'd0});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_block(8, 64'hCAFEF00D12345678, 1, 0, 1, {$urandom, $urandom}, 1, 1);

    // random blocks
    for (int b = 0; b < 40; b++)
      send_block($urandom_range(1, 8), {$urandom, $urandom}, $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), {$urandom, $urandom}, 1, 1);

    t = 0;
    while ((blk_q.size() != 0 || bdo_q.size() != 0) && t < 200) begin @(negedge clk); t++; end
    chk("queues_drained", {blk_q.size() == 0, bdo_q.size() == 0}, 2'b11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
